key_press_pulse: RTL and testbench

Input conditioner that sits directly upstream of the tug-of-war playfield logic. It takes raw, active-low, asynchronous pushbutton levels, synchronizes and debounces each one, and emits exactly one single-cycle `press` pulse per physical press. The playfield therefore advances at most one position per press, however long the key is held. Multiple keys are conditioned in parallel and independently.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_press_pulse_if.sv | 12 +
 rtl/key_debounce.sv | 94 +++++++++
 rtl/key_press_pulse.sv | 32 +++
 tb/tb_key_press_pulse.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared constants and types for the key conditioning block.
// Optional feature macro: KEY_DEBOUNCE_EN (debounce counters present when defined).
package key_pkg;

    localparam int KEY_DEBOUNCE_DEFAULT = 16;
    localparam int KEY_NUM_PLAYERS      = 2;

    typedef logic [KEY_NUM_PLAYERS-1:0] key_vec_t;

    // Counter width able to hold DEBOUNCE_CYCLES; never narrower than one bit.
    function automatic int key_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_press_pulse_if.sv
// Key bus: raw active-low key levels in, debounced level and press pulses out.
// Optional feature macro: KEY_DEBOUNCE_EN (affects the block behind this bus only).
interface key_press_pulse_if #(
    parameter int N_KEYS = key_pkg::KEY_NUM_PLAYERS
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] held;
    logic [N_KEYS-1:0] press;

    modport master (output key_n, input held, input press);
    modport slave  (input key_n, output held, output press);
endinterface

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchronizer, debounce counter, arm flag
// and one-cycle press pulse.
// Optional feature macro: KEY_DEBOUNCE_EN. When undefined the counter is
// removed and the debounced level simply follows the synchronized level.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic held_o,
    output logic press_o
);

    logic [1:0] sync_q;
    logic [1:0] fill_q;
    logic       held_q,  held_d;
    logic       armed_q, armed_d;
    logic       press_q, press_d;
    logic       s;
    logic       accept;

    assign s = sync_q[1];

    // Synchronize the inverted key; fill_q marks when sync_q holds real samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[0], ~key_n_i};
            fill_q <= {fill_q[0], 1'b1};
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int             CW       = key_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized level disagrees with held.
    always_comb begin
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (s == held_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            accept = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    // No counter: any disagreement is accepted on the next edge.
    assign accept = (s != held_q) && (DEBOUNCE_CYCLES >= 1);
`endif

    // Next held level, arm flag and press pulse. The synchronizer reads
    // "released" for two edges after reset whatever the pin does, so arming
    // waits until it carries real samples; a key held across reset stays
    // unreported until it has been released.
    always_comb begin
        held_d  = accept ? s : held_q;
        armed_d = armed_q | (fill_q[1] & ~held_q & ~s);
        press_d = armed_q & accept & s & ~held_q;
    end

    // State register for held, arm and pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q  <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            held_q  <= held_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign held_o  = held_q;
    assign press_o = press_q;

endmodule

// File: rtl/key_press_pulse.sv
// Multi-key press conditioner: one independent key_debounce per key.
// Optional feature macro: KEY_DEBOUNCE_EN (debounce counters present when defined).
module key_press_pulse
    import key_pkg::*;
#(
    parameter int N_KEYS          = KEY_NUM_PLAYERS,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    key_press_pulse_if.slave bus
);

    logic [N_KEYS-1:0] held_w;
    logic [N_KEYS-1:0] press_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .key_n_i (bus.key_n[i]),
            .held_o  (held_w[i]),
            .press_o (press_w[i])
        );
    end

    assign bus.held  = held_w;
    assign bus.press = press_w;

endmodule

// File: tb/tb_key_press_pulse.sv
// Bench for key_press_pulse: directed scenarios plus random key activity,
// compared each cycle against a window-based reference model.
// Optional feature macro: KEY_DEBOUNCE_EN (bench adapts its expected latency).
module tb_key_press_pulse;

    localparam int NK = 2;
    localparam int DC = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int DEFF = DC;
`else
    localparam int DEFF = 1;
`endif
    localparam int LAT = 1 + DEFF;

    logic clk = 1'b0;
    logic reset = 1'b1;

    key_press_pulse_if #(.N_KEYS(NK)) bus ();

    key_press_pulse #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: a key flips its debounced level once the last DEFF
    // synchronized samples all disagree with it. The synchronized sample at
    // an edge is the raw pressed level seen two edges earlier.
    logic [NK-1:0][1:0]  m_raw;
    logic [NK-1:0][31:0] m_shist;
    logic [NK-1:0]       m_held, m_press, m_armed;
    int                  m_edges;

    function automatic logic flip_f(input logic [31:0] win, input logic hold);
        logic [31:0] mask;
        mask = (32'd1 << DEFF) - 32'd1;
        return hold ? ((win & mask) == 32'd0) : ((win & mask) == mask);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_raw   <= '0;
            m_shist <= '0;
            m_held  <= '0;
            m_press <= '0;
            m_armed <= '0;
            m_edges <= 0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                m_raw[i]   <= {m_raw[i][0], ~bus.key_n[i]};
                m_shist[i] <= {m_shist[i][30:0], m_raw[i][1]};
                m_press[i] <= m_armed[i] & ~m_held[i] &
                              flip_f({m_shist[i][30:0], m_raw[i][1]}, m_held[i]);
                if (flip_f({m_shist[i][30:0], m_raw[i][1]}, m_held[i]))
                    m_held[i] <= ~m_held[i];
                if (m_edges >= 2 && !m_held[i] && !m_raw[i][1])
                    m_armed[i] <= 1'b1;
            end
            if (m_edges < 2) m_edges <= m_edges + 1;
        end
    end

    task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare against the model on the falling edge.
    task automatic cyc();
        @(negedge clk);
        chk("model_held", bus.held, m_held);
        chk("model_press", bus.press, m_press);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc();
    endtask

    int n0, n1;

    initial begin
        bus.key_n = 2'b11;
        reset     = 1'b1;

        // Reset values, checked while reset is held.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rst_held", bus.held, 2'b00);
            chk("rst_press", bus.press, 2'b00);
        end
        reset = 1'b0;
        idle(6);

        // Clean press on key 0: pulse exactly after edge k+LAT.
        bus.key_n[0] = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            cyc();
            chk("clean_press", bus.press, (j == LAT + 1) ? 2'b01 : 2'b00);
            chk("clean_held", bus.held, (j >= LAT + 1) ? 2'b01 : 2'b00);
        end
        bus.key_n[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            chk("clean_release", bus.held, (j >= LAT + 1) ? 2'b00 : 2'b01);
        end

        // Bounce on key 1: low 3 / high 1, five times, then low.
        n1 = 0;
        for (int r = 0; r < 5; r++) begin
            bus.key_n[1] = 1'b0;
            for (int j = 0; j < 3; j++) begin cyc(); if (bus.press[1]) n1++; end
            bus.key_n[1] = 1'b1;
            cyc(); if (bus.press[1]) n1++;
        end
        bus.key_n[1] = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            if (bus.press[1]) n1++;
            if (DEFF > 1) chk("bounce_final", bus.press, (j == LAT + 1) ? 2'b10 : 2'b00);
        end
        chk_int("bounce_count", n1, (DEFF == 1) ? 6 : 1);
        bus.key_n = 2'b11;
        idle(12);

        // Simultaneous presses on both keys.
        bus.key_n = 2'b00;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            chk("simul_press", bus.press, (j == LAT + 1) ? 2'b11 : 2'b00);
        end
        // Release key 0 for six cycles, then press again.
        bus.key_n[0] = 1'b1;
        idle(6);
        n0 = 0;
        bus.key_n[0] = 1'b0;
        for (int j = 0; j < 12; j++) begin cyc(); if (bus.press[0]) n0++; end
        chk_int("second_press", n0, 1);
        bus.key_n = 2'b11;
        idle(12);

        // Key 0 held across reset release: no pulse until released and re-pressed.
        bus.key_n[0] = 1'b0;
        idle(10);
        reset = 1'b1;
        #1;
        chk("held_rst_async", bus.held, 2'b00);
        idle(3);
        reset = 1'b0;
        n0 = 0;
        for (int j = 0; j < 20; j++) begin cyc(); if (bus.press[0]) n0++; end
        chk_int("held_through_reset", n0, 0);
        bus.key_n[0] = 1'b1;
        idle(10);
        n0 = 0;
        bus.key_n[0] = 1'b0;
        for (int j = 0; j < 12; j++) begin cyc(); if (bus.press[0]) n0++; end
        chk_int("repress_after_reset", n0, 1);
        bus.key_n = 2'b11;
        idle(12);

        // Reset in the middle of a count on key 1, key kept low afterwards.
        bus.key_n[1] = 1'b0;
        idle(4);
        reset = 1'b1;
        #1;
        chk("midcount_held", bus.held, 2'b00);
        chk("midcount_press", bus.press, 2'b00);
        idle(2);
        reset = 1'b0;
        n1 = 0;
        for (int j = 0; j < 20; j++) begin cyc(); if (bus.press[1]) n1++; end
        chk_int("midcount_no_pulse", n1, 0);
        bus.key_n = 2'b11;
        idle(12);

        // Random key activity with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NK; i++)
                if ($urandom_range(5) == 0) bus.key_n[i] = ~bus.key_n[i];
            if ($urandom_range(149) == 0) reset = 1'b1;
            cyc();
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
